nic_register_interface: RTL



---
 rtl/nic_register_interface.sv | 107 ++++++++++
 1 files changed

// File: rtl/nic_register_interface.sv
// Processor-side NIC register block: single-entry input and output channel buffers,
// memory-mapped load/store access, and a polarity-gated send/ready router handshake.
module nic_register_interface #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = DATA_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic [1:0]            adder_nic,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    typedef enum logic [1:0] {
        ADDR_IN_BUF   = 2'b00,
        ADDR_IN_STAT  = 2'b01,
        ADDR_OUT_BUF  = 2'b10,
        ADDR_OUT_STAT = 2'b11
    } reg_addr_e;

    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  out_drop;

    reg_addr_e addr;
    logic      load;
    logic      store;
    logic      deposit;
    logic      in_read;
    logic      out_write;
    logic      out_reject;
    logic      stat_read;

    assign addr  = reg_addr_e'(adder_nic);
    assign load  = nicEn & ~nicEnWr;
    assign store = nicEn & nicEnWr;

    assign net_ri  = ~in_full;
    assign deposit = net_si & net_ri;
    assign in_read = load & (addr == ADDR_IN_BUF) & in_full;

    // The full check uses the pre-edge flag, so a store racing a send is still dropped.
    assign out_write  = store & (addr == ADDR_OUT_BUF) & ~out_full;
    assign out_reject = store & (addr == ADDR_OUT_BUF) & out_full;
    assign stat_read  = load & (addr == ADDR_OUT_STAT);

    assign net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity);
    assign net_do = out_buf;

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        d_out = '0;
        if (nicEn && !nicEnWr) begin
            case (addr)
                ADDR_IN_BUF:   d_out = in_buf;
                ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_BUF:  d_out = out_buf;
                ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-2){1'b0}}, out_drop, out_full};
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every branch sees pre-edge values.
    // NOTE: the data buffers are cleared on reset too, so d_out and net_do read 0 afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf   <= '0;
            out_buf  <= '0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
            out_drop <= 1'b0;
        end else begin
            // deposit needs in_full=0 and in_read needs in_full=1, so they never collide
            if (deposit) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (in_read) begin
                in_full <= 1'b0;
            end

            if (out_write) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end else if (net_so) begin
                out_full <= 1'b0;
            end

            if (out_reject) begin
                out_drop <= 1'b1;
            end else if (stat_read) begin
                out_drop <= 1'b0;
            end
        end
    end

endmodule
